// File: rtl/sdrc_wb_arbiter.sv
// sdrc_wb_arbiter: round-robin Wishbone arbiter that shares the sdrc_top slave port among NM masters.
// One master owns the slave port for a whole bus cycle (cyc held). Between two grants there is
// always one dead (idle) cycle.
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i      per-master request controls (NM bits)
//   m_addr_i/m_dat_i/m_sel_i    packed per-master address/data/select; master k at [k*W +: W]
//   m_ack_o/m_err_o             per-master acknowledge / timeout error
//   m_dat_o                     read data broadcast, valid only with own m_ack_o
//   s_*_o, s_ack_i, s_dat_i     slave (controller) side
//   grant_o                     one-hot current grant
// Optional feature: define SDRC_ARB_TIMEOUT_EN to add a stall timeout that errors the master
// and releases the bus after TIMEOUT_CYC unacknowledged strobe cycles.
module sdrc_wb_arbiter #(
  parameter int unsigned NM          = 2,
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 26,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*AW-1:0]     m_addr_i,
  input  logic [NM*DW-1:0]     m_dat_i,
  input  logic [NM*DW/8-1:0]   m_sel_i,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [DW-1:0]        m_dat_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [AW-1:0]        s_addr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [DW/8-1:0]      s_sel_o,
  input  logic                 s_ack_i,
  input  logic [DW-1:0]        s_dat_i,
  output logic [NM-1:0]        grant_o
);

  localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned SW = DW / 8;
  localparam logic [IW:0] NmW = (IW + 1)'(NM);

`ifdef SDRC_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tcnt_q, tcnt_d;
`else
  typedef enum logic [1:0] {StIdle, StBusy} state_e;
`endif

  state_e        state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] pick_idx, next_ptr;
  logic          pick_valid;
  logic [2*NM-1:0] rot;
  logic [IW:0]   pick_sum;

  logic          g_cyc, g_stb, g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_dat;
  logic [SW-1:0] g_sel;

  // Rotate requests so bit 0 is the master at rr_ptr; the first set bit wins.
  always_comb begin
    rot        = {m_cyc_i, m_cyc_i} >> rr_ptr_q;
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_sum   = '0;
    for (int i = 0; i < int'(NM); i++) begin
      if (!pick_valid && rot[i]) begin
        pick_valid = 1'b1;
        pick_sum   = {1'b0, rr_ptr_q} + (IW + 1)'(i);
        if (pick_sum >= NmW) pick_sum = pick_sum - NmW;
        pick_idx   = pick_sum[IW-1:0];
      end
    end
  end

  assign next_ptr = (gidx_q == IW'(NM - 1)) ? '0 : gidx_q + IW'(1);

  // Granted master's signals.
  always_comb begin
    g_cyc  = 1'b0;
    g_stb  = 1'b0;
    g_we   = 1'b0;
    g_addr = '0;
    g_dat  = '0;
    g_sel  = '0;
    for (int k = 0; k < int'(NM); k++) begin
      if (gidx_q == IW'(k)) begin
        g_cyc  = m_cyc_i[k];
        g_stb  = m_stb_i[k];
        g_we   = m_we_i[k];
        g_addr = m_addr_i[k*AW +: AW];
        g_dat  = m_dat_i[k*DW +: DW];
        g_sel  = m_sel_i[k*SW +: SW];
      end
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    m_dat_o  = s_dat_i;
    if (state_q == StBusy) begin
      s_cyc_o  = g_cyc;
      s_stb_o  = g_stb;
      s_we_o   = g_we;
      s_addr_o = g_addr;
      s_dat_o  = g_dat;
      s_sel_o  = g_sel;
      // Acks without a strobe are dropped.
      m_ack_o  = grant_q & {NM{s_ack_i & g_stb}};
    end
`ifdef SDRC_ARB_TIMEOUT_EN
    if (state_q == StErr) m_err_o = grant_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StBusy;
          gidx_d  = pick_idx;
          grant_d = NM'(1) << pick_idx;
        end
      end
      StBusy: begin
        if (!g_cyc) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
`ifdef SDRC_ARB_TIMEOUT_EN
        else if (tcnt_q == CW'(TIMEOUT_CYC)) begin
          state_d = StErr;
        end
`endif
      end
`ifdef SDRC_ARB_TIMEOUT_EN
      StErr: begin
        state_d  = StIdle;
        grant_d  = '0;
        rr_ptr_d = next_ptr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

`ifdef SDRC_ARB_TIMEOUT_EN
  // Counts unacknowledged strobe cycles of the current owner.
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q != StBusy || state_d != StBusy) begin
      tcnt_d = '0;
    end else if (s_ack_i && g_stb) begin
      tcnt_d = '0;
    end else if (g_stb) begin
      tcnt_d = tcnt_q + CW'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) tcnt_q <= '0;
    else          tcnt_q <= tcnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// Randomized bench for sdrc_wb_arbiter with a bus-ownership reference model.
module tb_sdrc_wb_arbiter;
  localparam int NM = 3;
  localparam int DW = 32;
  localparam int AW = 26;
  localparam int SW = DW / 8;
  localparam int TO = 16;
  localparam int NCYC = 2000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]  m_addr_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*SW-1:0]  m_sel_i;
  logic [NM-1:0]     m_ack_o, m_err_o, grant_o;
  logic [DW-1:0]     m_dat_o, s_dat_o, s_dat_i;
  logic              s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [AW-1:0]     s_addr_o;
  logic [SW-1:0]     s_sel_o;

  sdrc_wb_arbiter #(.NM(NM), .DW(DW), .AW(AW), .TIMEOUT_CYC(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, where the round robin resumes, timeout bookkeeping.
  int  owner = -1;
  int  ptr = 0;
  int  tcnt = 0;
  bit  in_err = 1'b0;
  bit  to_en;
  logic [NM-1:0] exp_ack, exp_err;

  // Master generators: beats left in the current bus cycle, idle gap before next request.
  int  beats[NM];
  int  gap[NM];
  bit  stall = 1'b0;
  int  grants_seen = 0;

  task automatic check_outputs();
    logic [NM-1:0] eg;
    logic es_cyc, es_stb, es_we;
    logic [AW-1:0] es_addr;
    logic [DW-1:0] es_dat;
    logic [SW-1:0] es_sel;
    eg = '0; exp_ack = '0; exp_err = '0;
    es_cyc = 0; es_stb = 0; es_we = 0; es_addr = '0; es_dat = '0; es_sel = '0;
    for (int k = 0; k < NM; k++) begin
      if (k == owner) begin
        eg[k] = 1'b1;
        if (in_err) begin
          exp_err[k] = 1'b1;
        end else begin
          es_cyc     = m_cyc_i[k];
          es_stb     = m_stb_i[k];
          es_we      = m_we_i[k];
          es_addr    = m_addr_i[k*AW +: AW];
          es_dat     = m_dat_i[k*DW +: DW];
          es_sel     = m_sel_i[k*SW +: SW];
          exp_ack[k] = s_ack_i & m_stb_i[k];
        end
      end
    end
    check("grant", grant_o, eg);
    check("s_cyc", s_cyc_o, es_cyc);
    check("s_stb", s_stb_o, es_stb);
    check("s_we", s_we_o, es_we);
    check("s_addr", s_addr_o, es_addr);
    check("s_dat", s_dat_o, es_dat);
    check("s_sel", s_sel_o, es_sel);
    check("m_ack", m_ack_o, exp_ack);
    check("m_err", m_err_o, exp_err);
    if (exp_ack != '0) check("m_dat", m_dat_o, s_dat_i);
  endtask

  // Advance the model across one rising edge using the inputs present before it.
  task automatic step_model();
    bit found;
    if (rst) begin
      owner = -1; ptr = 0; tcnt = 0; in_err = 1'b0;
    end else if (in_err) begin
      ptr = (owner + 1) % NM; owner = -1; in_err = 1'b0;
    end else if (owner < 0) begin
      found = 1'b0;
      for (int i = 0; i < NM; i++) begin
        if (!found && m_cyc_i[(ptr + i) % NM]) begin
          found = 1'b1; owner = (ptr + i) % NM; grants_seen++;
        end
      end
    end else if (!m_cyc_i[owner]) begin
      ptr = (owner + 1) % NM; owner = -1; tcnt = 0;
    end else if (to_en && tcnt == TO) begin
      in_err = 1'b1; tcnt = 0;
    end else if (m_stb_i[owner] && s_ack_i) begin
      tcnt = 0;
    end else if (m_stb_i[owner]) begin
      tcnt++;
    end
  endtask

  task automatic drive_inputs(input bit was_rst, input logic [NM-1:0] ack, input logic [NM-1:0] err);
    for (int k = 0; k < NM; k++) begin
      if (was_rst) begin
        beats[k] = 0; gap[k] = 0;
      end else if (beats[k] > 0) begin
        if (ack[k]) beats[k]--;
        if (err[k]) beats[k] = 0;
        if (beats[k] == 0) gap[k] = $urandom_range(0, 2);
      end else if (gap[k] > 0) begin
        gap[k]--;
      end else if ($urandom_range(0, 1) == 1) begin
        beats[k] = $urandom_range(1, 4);
      end
      m_cyc_i[k] = (beats[k] > 0);
      m_stb_i[k] = (beats[k] > 0) && ($urandom_range(0, 3) != 0);
      m_we_i[k]  = 1'($urandom_range(0, 1));
      m_addr_i[k*AW +: AW] = AW'($urandom);
      m_dat_i[k*DW +: DW]  = $urandom;
      m_sel_i[k*SW +: SW]  = SW'($urandom);
    end
    s_ack_i = stall ? 1'b0 : 1'($urandom_range(0, 1));
    s_dat_i = $urandom;
  endtask

  initial begin
    bit was_rst;
    logic [NM-1:0] sv_ack, sv_err;
`ifdef SDRC_ARB_TIMEOUT_EN
    to_en = 1'b1;
`else
    to_en = 1'b0;
`endif
    for (int k = 0; k < NM; k++) begin beats[k] = 0; gap[k] = 0; end
    rst = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_addr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
    @(posedge clk); #1;
    check("rst_grant", grant_o, '0);
    check("rst_s_cyc", s_cyc_o, 1'b0);
    check("rst_m_ack", m_ack_o, '0);
    check("rst_m_err", m_err_o, '0);
    for (int c = 0; c < NCYC; c++) begin
      #1;
      check_outputs();
      sv_ack = exp_ack;
      sv_err = exp_err;
      step_model();
      was_rst = rst;
      @(posedge clk); #1;
      rst   = (c == 700);
      stall = (c >= 1200 && c < 1260);
      drive_inputs(was_rst, sv_ack, sv_err);
    end
    check("grants_made", grants_seen > 50, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
